serial_addsub_accum: RTL and testbench

Parametrised bit-serial add/subtract/accumulate unit: one 1-bit full-adder slice with a registered carry, iterated over a WIDTH-bit word, LSB first. Next generation of the team's single-bit full adder: configurable width, subtract and accumulate modes, flags, and a start/busy/done handshake. Sits between the tile's input pins and output pins as a small arithmetic engine, trading latency (WIDTH cycles) for area.

---
 rtl/serial_addsub_accum_pkg.sv | 15 +
 rtl/serial_addsub_accum_if.sv | 25 ++
 rtl/serial_addsub_accum_full_adder_cell.sv | 11 +
 rtl/serial_addsub_accum.sv | 109 ++++++++++
 tb/tb_serial_addsub_accum.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_accum_pkg.sv
// Shared constants and types for the bit-serial add/subtract/accumulate engine.
package serial_addsub_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_ACC    = 2'b10;
  localparam logic [1:0] OP_ACCSUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_addsub_accum_if.sv
// Request/response bundle of the serial add/sub/accumulate engine.
interface serial_addsub_accum_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ena;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output ena, start, op, a, b,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  ena, start, op, a, b,
        output busy, done, result, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_accum_full_adder_cell.sv
// Combinational single-bit full adder; the one arithmetic slice of the serial engine.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_addsub_accum.sv
// Bit-serial add/sub/accumulate: one full-adder slice iterated LSB first over WIDTH bits,
// with a start/busy/done handshake and carry/overflow flags.
module serial_addsub_accum
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_addsub_accum_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic is_sub, use_acc;
    logic fa_sum, fa_cout;

    full_adder_cell u_fa (
        .a    (x_q[0]),
        .b    (y_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        is_sub   = bus.op[0];
        use_acc  = bus.op[1];

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is x + ~y + 1, so invert Y and seed the carry.
                    x_d     = use_acc ? result_q : bus.a;
                    y_d     = (use_acc ? bus.a : bus.b) ^ {WIDTH{is_sub}};
                    carry_d = is_sub;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                x_d     = x_q >> 1;
                y_d     = y_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    result_d = sum_d;
                    cout_d   = fa_cout;
                    ovf_d    = fa_cout ^ carry_q;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.ena) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_addsub_accum.sv
// Directed bench for serial_addsub_accum: vector table at WIDTH=8 plus freeze, reset and
// WIDTH=2/32 corner sequences.
module tb_serial_addsub_accum;
    import serial_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_addsub_accum_if #(.WIDTH(8))  bus8 ();
    serial_addsub_accum_if #(.WIDTH(2))  bus2 ();
    serial_addsub_accum_if #(.WIDTH(32)) bus32 ();

    serial_addsub_accum #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_addsub_accum #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));
    serial_addsub_accum #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic       rst_first;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one op on the 8-bit unit and check latency, busy span, flags and done drop.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] res, input logic co,
                          input logic ov);
        int n;
        int bcnt;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bcnt = int'(bus8.busy);
        n    = 0;
        while (!bus8.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus8.done) bcnt += int'(bus8.busy);
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_cycles"}, bcnt, 8);
        check({tag, "_result"}, {24'd0, bus8.result}, {24'd0, res});
        check({tag, "_cout"}, {31'd0, bus8.cout}, {31'd0, co});
        check({tag, "_ovf"}, {31'd0, bus8.ovf}, {31'd0, ov});
        @(posedge clk);
        #1;
        check({tag, "_done_drop"}, {31'd0, bus8.done}, 32'd0);
    endtask

    initial begin
        int n;
        int n2;
        int n32;

        vecs[0] = '{1'b0, OP_ADD,    8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{1'b0, OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, OP_SUB,    8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, OP_SUB,    8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{1'b1, OP_ACC,    8'h70, 8'hAA, 8'h70, 1'b0, 1'b0};
        vecs[5] = '{1'b0, OP_ACC,    8'h20, 8'h55, 8'h90, 1'b0, 1'b1};
        vecs[6] = '{1'b0, OP_ACCSUB, 8'h90, 8'h11, 8'h00, 1'b1, 1'b0};

        bus8.ena = 1'b1;  bus8.start = 1'b0;  bus8.op = OP_ADD;  bus8.a = '0;  bus8.b = '0;
        bus2.ena = 1'b1;  bus2.start = 1'b0;  bus2.op = OP_ADD;  bus2.a = '0;  bus2.b = '0;
        bus32.ena = 1'b1; bus32.start = 1'b0; bus32.op = OP_ADD; bus32.a = '0; bus32.b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus8.busy}, 32'd0);
        check("rst_done",   {31'd0, bus8.done}, 32'd0);
        check("rst_result", {24'd0, bus8.result}, 32'd0);
        check("rst_cout",   {31'd0, bus8.cout}, 32'd0);
        check("rst_ovf",    {31'd0, bus8.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=2 and WIDTH=32: all-ones + 1 wraps to zero with carry out.
        @(negedge clk);
        bus2.start = 1'b1;  bus2.a = 2'b11;   bus2.b = 2'b01;
        bus32.start = 1'b1; bus32.a = '1;     bus32.b = 32'd1;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        bus32.start = 1'b0;
        n = 0; n2 = -1; n32 = -1;
        while ((n2 < 0 || n32 < 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus2.done && n2 < 0) n2 = n;
            if (bus32.done && n32 < 0) n32 = n;
        end
        check("w2_latency",  n2, 2);
        check("w2_result",   {30'd0, bus2.result}, 32'd0);
        check("w2_cout",     {31'd0, bus2.cout}, 32'd1);
        check("w32_latency", n32, 32);
        check("w32_result",  bus32.result, 32'd0);
        check("w32_cout",    {31'd0, bus32.cout}, 32'd1);
        check("w32_ovf",     {31'd0, bus32.ovf}, 32'd0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].rst_first) pulse_reset();
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].cout, vecs[i].ovf);
        end

        // Freeze 3 cycles mid-run while hammering start and changing operands.
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = OP_ADD; bus8.a = 8'h5A; bus8.b = 8'h33;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = OP_SUB; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(posedge clk);
        n++;
        @(negedge clk);
        bus8.start = 1'b0;
        @(posedge clk);
        n++;
        @(negedge clk);
        bus8.ena = 1'b0; bus8.start = 1'b1; bus8.a = 8'h01;
        repeat (3) @(posedge clk);
        n += 3;
        @(negedge clk);
        bus8.ena = 1'b1; bus8.start = 1'b0;
        while (!bus8.done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frz_latency", n, 11);
        check("frz_result", {24'd0, bus8.result}, 32'h8D);
        check("frz_ovf",    {31'd0, bus8.ovf}, 32'd1);
        @(negedge clk);
        bus8.ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("frz_done_held", {31'd0, bus8.done}, 32'd1);
        @(negedge clk);
        bus8.ena = 1'b1;
        @(posedge clk);
        #1;
        check("frz_done_drop", {31'd0, bus8.done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("frz_no_second_op", {31'd0, bus8.busy}, 32'd0);

        // Async reset with the bit counter at 4: outputs clear before any clock edge.
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = OP_ADD; bus8.a = 8'hFF; bus8.b = 8'hFF;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, bus8.busy}, 32'd0);
        check("arst_done",   {31'd0, bus8.done}, 32'd0);
        check("arst_result", {24'd0, bus8.result}, 32'd0);
        check("arst_cout",   {31'd0, bus8.cout}, 32'd0);
        check("arst_ovf",    {31'd0, bus8.ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
